// File: rtl/monster_hit_scheduler_if.sv
// Hit request bus between the projectile sources and the hit scheduler.
//   hit_req : per-source hit request (level or pulse)
//   hit_dmg : per-source damage, source i on bits [i*DMG_W +: DMG_W]
//   hit_ack : one-hot, one-cycle grant back to the winning source
// master = projectile sources, slave = scheduler.
interface monster_hit_scheduler_if #(
    parameter int unsigned N_SRC = 4,
    parameter int unsigned DMG_W = 3
);
    logic [N_SRC-1:0]       hit_req;
    logic [N_SRC*DMG_W-1:0] hit_dmg;
    logic [N_SRC-1:0]       hit_ack;

    modport master (output hit_req, output hit_dmg, input hit_ack);
    modport slave  (input hit_req, input hit_dmg, output hit_ack);
endinterface

// File: rtl/monster_hit_scheduler.sv
// Monster hit scheduler: round-robin arbitration of hit requests, expansion
// of each granted hit into one got_hit pulse per health unit, a frame-counted
// invulnerability window after each hit, and the authoritative health count.
// Ports:
//   clk, reset    : system clock, synchronous active-high reset
//   startOfFrame  : one-cycle pulse per video frame
//   hits          : hit request bus (slave side), see monster_hit_scheduler_if
//   got_hit       : one-cycle decrement pulse to the health bar
//   health        : current health
//   invulnerable  : high while a hit is applied and during cooldown
//   enraged       : high when 0 < health <= ENRAGE_LEVEL
//   monster_dead  : high once health reaches 0, sticky until reset
module monster_hit_scheduler #(
    parameter int unsigned N_SRC         = 4,
    parameter int unsigned MAX_HEALTH    = 32,
    parameter int unsigned DMG_W         = 3,
    parameter int unsigned INVULN_FRAMES = 8,
    parameter int unsigned ENRAGE_LEVEL  = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic startOfFrame,
    monster_hit_scheduler_if.slave hits,
    output logic       got_hit,
    output logic [7:0] health,
    output logic       invulnerable,
    output logic       enraged,
    output logic       monster_dead
);
    localparam int unsigned PTR_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam int unsigned FC_W  = (INVULN_FRAMES > 0) ? $clog2(INVULN_FRAMES + 1) : 1;

    typedef enum logic [1:0] {IDLE, APPLY, COOLDOWN, DEAD} state_t;

    state_t           state;
    logic [PTR_W-1:0] ptr;
    logic [7:0]       remain;
    logic [FC_W-1:0]  frame_cnt;

    logic             grant_valid;
    logic [PTR_W-1:0] grant_idx;
    logic [PTR_W-1:0] cand_idx;
    logic [N_SRC-1:0] ack_vec;
    logic [DMG_W-1:0] dmg_sel;
    logic [31:0]      dmg_eff;
    logic [7:0]       remain_load;

    // Round-robin search starting just after the last granted source.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand_idx    = '0;
        for (int unsigned i = 1; i <= N_SRC; i++) begin
            cand_idx = PTR_W'((32'(ptr) + i) % N_SRC);
            if (!grant_valid && hits.hit_req[cand_idx]) begin
                grant_valid = 1'b1;
                grant_idx   = cand_idx;
            end
        end
        ack_vec            = '0;
        ack_vec[grant_idx] = 1'b1;
        dmg_sel            = hits.hit_dmg[grant_idx*DMG_W +: DMG_W];
        // Zero damage still costs one unit; clip to health so it never underflows.
        dmg_eff            = (dmg_sel == '0) ? 32'd1 : 32'(dmg_sel);
        remain_load        = (dmg_eff > 32'(health)) ? health : dmg_eff[7:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            ptr          <= PTR_W'(N_SRC - 1);
            health       <= 8'(MAX_HEALTH);
            remain       <= '0;
            frame_cnt    <= '0;
            hits.hit_ack <= '0;
            got_hit      <= 1'b0;
            monster_dead <= 1'b0;
        end else begin
            hits.hit_ack <= '0;
            got_hit      <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        hits.hit_ack <= ack_vec;
                        ptr          <= grant_idx;
                        remain       <= remain_load;
                        state        <= APPLY;
                    end
                end
                APPLY: begin
                    got_hit <= 1'b1;
                    health  <= health - 8'd1;
                    remain  <= remain - 8'd1;
                    if (remain == 8'd1) begin
                        if (health == 8'd1) begin
                            state        <= DEAD;
                            monster_dead <= 1'b1;
                        end else if (INVULN_FRAMES == 0) begin
                            state <= IDLE;
                        end else begin
                            state     <= COOLDOWN;
                            frame_cnt <= FC_W'(INVULN_FRAMES);
                        end
                    end
                end
                COOLDOWN: begin
                    if (startOfFrame) begin
                        frame_cnt <= frame_cnt - FC_W'(1);
                        if (frame_cnt == FC_W'(1)) begin
                            state <= IDLE;
                        end
                    end
                end
                DEAD: begin
                    monster_dead <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign invulnerable = (state == APPLY) || (state == COOLDOWN);
    assign enraged      = (health != 8'd0) && (32'(health) <= ENRAGE_LEVEL);
endmodule
